// File: rtl/mux_tree16_reg_if.sv
// mux_tree16_reg_if: select/data/result bundle between a source and the registered selector
interface mux_tree16_reg_if #(parameter int BUS_WIDTH = 4);
  logic                 en;
  logic [1:0]           mode;
  logic [3:0]           sel;
  logic [BUS_WIDTH-1:0] din [16];
  logic [BUS_WIDTH-1:0] mux_out;
  logic [BUS_WIDTH-1:0] mux_comb;
  modport master (output en, mode, sel, din, input mux_out, mux_comb);
  modport slave (input en, mode, sel, din, output mux_out, mux_comb);
endinterface

// File: rtl/mux_tree16_reg.sv
// mux_tree16_reg: 2:1 / 4:1 / 16:1 mux tree with a registered output and hold mode
module mux_tree16_reg #(
  parameter int BUS_WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_tree16_reg_if.slave  bus
);
  logic [3:0]           idx;
  logic [BUS_WIDTH-1:0] s2 [8];
  logic [BUS_WIDTH-1:0] s4 [4];
  logic [BUS_WIDTH-1:0] t2 [2];
  logic [BUS_WIDTH-1:0] s16;
  logic [BUS_WIDTH-1:0] mux_comb;
  logic [BUS_WIDTH-1:0] mux_out_d, mux_out_q;
  // sel arrives MSB-first, so the index is its bit reversal
  assign idx = {bus.sel[0], bus.sel[1], bus.sel[2], bus.sel[3]};
  // tree: four 4:1 stages (each two 2:1 levels) feeding one 4:1 stage; modes 0/1 tap stage 0
  always_comb begin
    for (int k = 0; k < 8; k++) s2[k] = idx[0] ? bus.din[2*k+1] : bus.din[2*k];
    for (int k = 0; k < 4; k++) s4[k] = idx[1] ? s2[2*k+1] : s2[2*k];
    t2[0] = idx[2] ? s4[1] : s4[0];
    t2[1] = idx[2] ? s4[3] : s4[2];
    s16 = idx[3] ? t2[1] : t2[0];
    mux_comb = bus.mode == 2'd3 ? mux_out_q :
               bus.mode == 2'd2 ? s16 :
               bus.mode == 2'd1 ? s4[0] : s2[0];
    mux_out_d = (bus.en && bus.mode != 2'd3) ? mux_comb : mux_out_q;
  end
  // output register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) mux_out_q <= '0;
    else mux_out_q <= mux_out_d;
  end
  assign bus.mux_comb = mux_comb;
  assign bus.mux_out  = mux_out_q;
endmodule

// File: tb/tb_mux_tree16_reg.sv
// tb_mux_tree16_reg: directed scoreboard bench over 4-, 1- and 16-bit instances
module tb_mux_tree16_reg;
  typedef struct {
    logic [3:0]  e4;
    logic        e1;
    logic [15:0] e16;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  exp_t sb [$];
  logic [3:0]  m4;
  logic        m1;
  logic [15:0] m16;
  mux_tree16_reg_if #(.BUS_WIDTH(4))  b4 ();
  mux_tree16_reg_if #(.BUS_WIDTH(1))  b1 ();
  mux_tree16_reg_if #(.BUS_WIDTH(16)) b16 ();
  mux_tree16_reg #(.BUS_WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_tree16_reg #(.BUS_WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_tree16_reg #(.BUS_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  task automatic step(input logic rn, input logic e, input logic [1:0] m, input logic [3:0] s);
    logic [3:0]  idx, k;
    logic [3:0]  c4;
    logic        c1;
    logic [15:0] c16;
    exp_t        x;
    @(negedge clk);
    rst_n = rn;
    b4.en = e;   b4.mode = m;  b4.sel = s;
    b1.en = e;   b1.mode = m;  b1.sel = s;
    b16.en = e;  b16.mode = m; b16.sel = s;
    idx = {s[0], s[1], s[2], s[3]};
    k = m == 2'd0 ? {3'b0, idx[0]} : m == 2'd1 ? {2'b0, idx[1:0]} : idx;
    c4  = m == 2'd3 ? m4  : k;
    c1  = m == 2'd3 ? m1  : k[0];
    c16 = m == 2'd3 ? m16 : 16'(k) * 16'd257;
    x.e4  = !rn ? 4'd0  : (e && m != 2'd3) ? c4  : m4;
    x.e1  = !rn ? 1'b0  : (e && m != 2'd3) ? c1  : m1;
    x.e16 = !rn ? 16'd0 : (e && m != 2'd3) ? c16 : m16;
    sb.push_back(x);
    #1;
    check("comb4", 16'(b4.mux_comb), 16'(c4));
    check("comb1", 16'(b1.mux_comb), 16'(c1));
    check("comb16", b16.mux_comb, c16);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("out4", 16'(b4.mux_out), 16'(x.e4));
    check("out1", 16'(b1.mux_out), 16'(x.e1));
    check("out16", b16.mux_out, x.e16);
    m4 = x.e4;
    m1 = x.e1;
    m16 = x.e16;
  endtask
  function automatic logic [3:0] to_sel(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction
  initial begin
    rst_n = 1'b0;
    m4 = 'x; m1 = 'x; m16 = 'x;
    b4.en = 1'b0;  b4.mode = 2'd2;  b4.sel = 4'd0;
    b1.en = 1'b0;  b1.mode = 2'd2;  b1.sel = 4'd0;
    b16.en = 1'b0; b16.mode = 2'd2; b16.sel = 4'd0;
    for (int i = 0; i < 16; i++) begin
      b4.din[i]  = 4'(i);
      b1.din[i]  = 1'(i);
      b16.din[i] = 16'(i) * 16'd257;
    end
    step(1'b0, 1'b1, 2'd2, to_sel(4'd5));
    step(1'b0, 1'b1, 2'd2, to_sel(4'd5));
    step(1'b1, 1'b1, 2'd2, 4'b0000);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'd2, to_sel(4'(i)));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd1, to_sel(4'(i)));
    step(1'b1, 1'b1, 2'd1, to_sel(4'b1110));
    step(1'b1, 1'b1, 2'd0, 4'b0001);
    step(1'b1, 1'b1, 2'd0, 4'b1110);
    step(1'b1, 1'b1, 2'd2, to_sel(4'd5));
    step(1'b1, 1'b0, 2'd2, to_sel(4'd9));
    step(1'b1, 1'b0, 2'd2, to_sel(4'd9));
    step(1'b1, 1'b1, 2'd2, to_sel(4'd9));
    step(1'b1, 1'b1, 2'd3, to_sel(4'd3));
    step(1'b1, 1'b1, 2'd3, to_sel(4'd14));
    step(1'b1, 1'b1, 2'd2, to_sel(4'd12));
    step(1'b0, 1'b1, 2'd2, to_sel(4'd7));
    step(1'b1, 1'b1, 2'd2, to_sel(4'd7));
    step(1'b1, 1'b1, 2'd2, to_sel(4'd15));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
